// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg
// Definitions shared by the TX packet sequencer and the TX memory controller.
//   tx_state_e          : sequencer FSM encoding (IDLE=0, SEND=1, GAP=2, ROUND_END=3)
//   TX_HDR_BYTES        : header bytes per packet (46)
//   TX_PAYLOAD_BYTES    : payload bytes per packet (1440)
//   TX_PACKET_BYTES_DEF : default byte slots per packet
//   TX_GAP_CYCLES_DEF   : default inter-packet idle cycles
//   min1_u8 / min1_u16  : clamp a count so that 0 behaves as 1
// ---------------------------------------------------------------------------
package tx_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      GAP       = 2'd2,
      ROUND_END = 2'd3
   } tx_state_e;

   localparam int unsigned TX_HDR_BYTES        = 46;
   localparam int unsigned TX_PAYLOAD_BYTES    = 1440;
   localparam int unsigned TX_PACKET_BYTES_DEF = TX_HDR_BYTES + TX_PAYLOAD_BYTES;
   localparam int unsigned TX_GAP_CYCLES_DEF   = 20;

   function automatic logic [7:0] min1_u8(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

   function automatic logic [15:0] min1_u16(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

endpackage

// File: rtl/tx_seg_index_counter.sv
// ---------------------------------------------------------------------------
// tx_seg_index_counter
// Two-level packet index: segment_num counts 0..seg-1 inside each copy,
// txid counts copies 1..red. Limits are latched on load.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   load_i         : latch limits from red_i/seg_i (0 treated as 1), restart at (1,0)
//   red_i, seg_i   : copies per segment / segments per copy
//   adv_i          : step to the next (txid, segment) pair
//   clr_i          : return to (1,0) keeping the latched limits
//   txid_o         : current copy index, 1-based
//   seg_num_o      : current segment index
//   last_o         : current pair is the final one of the round
// ---------------------------------------------------------------------------
module tx_seg_index_counter
   import tx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        load_i,
   input  logic [7:0]  red_i,
   input  logic [15:0] seg_i,
   input  logic        adv_i,
   input  logic        clr_i,
   output logic [7:0]  txid_o,
   output logic [15:0] seg_num_o,
   output logic        last_o
);

   logic [7:0]  red_q,  red_d;
   logic [15:0] seg_q,  seg_d;
   logic [7:0]  txid_q, txid_d;
   logic [15:0] segn_q, segn_d;
   logic        seg_last;

   // 17-bit compare so segment 65535+1 cannot alias to 0.
   assign seg_last  = ({1'b0, segn_q} + 17'd1) >= {1'b0, seg_q};
   assign last_o    = seg_last && (txid_q >= red_q);
   assign txid_o    = txid_q;
   assign seg_num_o = segn_q;

   always_comb begin
      red_d  = red_q;
      seg_d  = seg_q;
      txid_d = txid_q;
      segn_d = segn_q;
      if (load_i) begin
         red_d  = min1_u8(red_i);
         seg_d  = min1_u16(seg_i);
         txid_d = 8'd1;
         segn_d = 16'd0;
      end else if (clr_i) begin
         txid_d = 8'd1;
         segn_d = 16'd0;
      end else if (adv_i && !last_o) begin
         if (!seg_last) begin
            segn_d = segn_q + 16'd1;
         end else begin
            segn_d = 16'd0;
            txid_d = txid_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         red_q  <= 8'd1;
         seg_q  <= 16'd1;
         txid_q <= 8'd1;
         segn_q <= 16'd0;
      end else begin
         red_q  <= red_d;
         seg_q  <= seg_d;
         txid_q <= txid_d;
         segn_q <= segn_d;
      end
   end

endmodule

// File: rtl/tx_packet_sequencer.sv
// ---------------------------------------------------------------------------
// tx_packet_sequencer
// Packet timing generator feeding the TX memory controller (clk125MHz domain).
// One round sends segments 0..segment_num_max-1 for each copy txid=1..redundancy,
// separated by GAP_CYCLES idle cycles; oneframe_done ends the round after the
// current packet and its gap.
// Optional feature macro: TX_PAUSE_EN adds the pause input, which holds the
// sequencer on the last gap cycle while asserted.
// Ports:
//   clk125MHz, rst_n   : clock, synchronous active-low reset
//   go                 : start a round when idle (level)
//   redundancy         : copies per segment, latched at round start (0 -> 1)
//   segment_num_max    : segments per copy, latched at round start (0 -> 1)
//   oneframe_done      : controller feedback, ends round after current packet
//   pause              : gap extension request (TX_PAUSE_EN only)
//   tx_active          : byte_data_counter valid (SEND)
//   byte_data_counter  : byte slot within the packet
//   txid, segment_num  : current copy / segment index
//   pkt_start          : pulse on byte 0 of each packet
//   round_done         : pulse in the round-end cycle
//   busy               : sequencer not idle
// ---------------------------------------------------------------------------
module tx_packet_sequencer
   import tx_pkg::*;
#(
   parameter int unsigned PACKET_BYTES = TX_PACKET_BYTES_DEF,
   parameter int unsigned GAP_CYCLES   = TX_GAP_CYCLES_DEF,
   parameter int unsigned CNT_W        = 12
)(
   input  logic             clk125MHz,
   input  logic             rst_n,
   input  logic             go,
   input  logic [7:0]       redundancy,
   input  logic [15:0]      segment_num_max,
   input  logic             oneframe_done,
`ifdef TX_PAUSE_EN
   input  logic             pause,
`endif
   output logic             tx_active,
   output logic [CNT_W-1:0] byte_data_counter,
   output logic [7:0]       txid,
   output logic [15:0]      segment_num,
   output logic             pkt_start,
   output logic             round_done,
   output logic             busy
);

   localparam int unsigned      GAP_W     = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(PACKET_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] byte_q,  byte_d;
   logic [GAP_W-1:0] gap_q,   gap_d;
   logic             stop_q,  stop_d;
   logic             stop_now;
   logic             idx_load, idx_adv, idx_clr, idx_last;
   logic             pause_w;

`ifdef TX_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   tx_seg_index_counter u_idx (
      .clk_i     (clk125MHz),
      .rst_n_i   (rst_n),
      .load_i    (idx_load),
      .red_i     (redundancy),
      .seg_i     (segment_num_max),
      .adv_i     (idx_adv),
      .clr_i     (idx_clr),
      .txid_o    (txid),
      .seg_num_o (segment_num),
      .last_o    (idx_last)
   );

   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      gap_d    = gap_q;
      stop_d   = stop_q;
      stop_now = 1'b0;
      idx_load = 1'b0;
      idx_adv  = 1'b0;
      idx_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            byte_d = '0;
            gap_d  = '0;
            stop_d = 1'b0;
            if (go) begin
               idx_load = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            stop_d = stop_q | oneframe_done;
            if (byte_q == BYTE_LAST) begin
               byte_d  = '0;
               gap_d   = '0;
               state_d = GAP;
            end else begin
               byte_d = byte_q + CNT_W'(1);
            end
         end
         GAP: begin
            // Include this cycle's feedback so a pulse on the final gap cycle still counts.
            stop_now = stop_q | oneframe_done;
            stop_d   = stop_now;
            if (gap_q != GAP_LAST) begin
               gap_d = gap_q + GAP_W'(1);
            end else if (!pause_w) begin
               gap_d = '0;
               if (stop_now || idx_last) begin
                  state_d = ROUND_END;
               end else begin
                  idx_adv = 1'b1;
                  state_d = SEND;
               end
            end
         end
         ROUND_END: begin
            stop_d  = 1'b0;
            idx_clr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk125MHz) begin
      if (!rst_n) begin
         state_q <= IDLE;
         byte_q  <= '0;
         gap_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         gap_q   <= gap_d;
         stop_q  <= stop_d;
      end
   end

   assign tx_active         = (state_q == SEND);
   assign byte_data_counter = byte_q;
   assign pkt_start         = (state_q == SEND) && (byte_q == '0);
   assign round_done        = (state_q == ROUND_END);
   assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_sequencer
// Scoreboard bench: each round issued pushes its expected (txid, segment)
// packet list and one expected round end; a monitor on the falling edge pops
// and compares packet order, packet length, byte sequence and gap lengths.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_packet_sequencer;

   localparam int PB  = 1486;
   localparam int GAP = 20;

   logic        clk = 1'b0;
   logic        rst_n, go, oneframe_done;
   logic [7:0]  redundancy;
   logic [15:0] segment_num_max;
`ifdef TX_PAUSE_EN
   logic        pause;
`endif
   logic        tx_active, pkt_start, round_done, busy;
   logic [11:0] byte_data_counter;
   logic [7:0]  txid;
   logic [15:0] segment_num;

   always #4 clk = ~clk;

   tx_packet_sequencer dut (
      .clk125MHz         (clk),
      .rst_n             (rst_n),
      .go                (go),
      .redundancy        (redundancy),
      .segment_num_max   (segment_num_max),
      .oneframe_done     (oneframe_done),
`ifdef TX_PAUSE_EN
      .pause             (pause),
`endif
      .tx_active         (tx_active),
      .byte_data_counter (byte_data_counter),
      .txid              (txid),
      .segment_num       (segment_num),
      .pkt_start         (pkt_start),
      .round_done        (round_done),
      .busy              (busy)
   );

   int checks = 0;
   int errors = 0;
   int exp_q[$];          // expected packets, encoded txid*65536 + segment
   int exp_rounds = 0;    // expected round_done pulses outstanding
   bit abort = 1'b0;      // set while the bench resets the DUT mid-round
   int gap_override = 0;  // one-shot expected length for the next inter-packet gap

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: the full round in (txid, segment) order, cut after stop_pkts packets if > 0.
   function automatic void model_round(input int red, input int seg, input int stop_pkts);
      int r = (red == 0) ? 1 : red;
      int s = (seg == 0) ? 1 : seg;
      int n = 0;
      exp_rounds++;
      for (int t = 1; t <= r; t++)
         for (int k = 0; k < s; k++) begin
            if (stop_pkts > 0 && n >= stop_pkts) return;
            exp_q.push_back(t * 65536 + k);
            n++;
         end
   endfunction

   // ---------------- monitor ----------------
   initial begin : monitor
      bit prev_tx = 0, in_round = 0, chk_idle = 0, bad_seq = 0;
      int gap_cnt = 0, pkt_len = 0, last_byte = 0, e, eg;
      forever begin
         @(negedge clk);
         if (!rst_n || abort) begin
            prev_tx = 0; in_round = 0; chk_idle = 0; gap_cnt = 0;
            exp_q.delete();
            exp_rounds = 0;
         end else begin
            if (chk_idle) begin
               chk("busy_after_round", busy, 0);
               chk("round_done_width", round_done, 0);
               chk_idle = 0;
            end
            if (tx_active) begin
               if (pkt_start) begin
                  chk("pkt_start_byte0", byte_data_counter, 0);
                  if (exp_q.size() == 0) begin
                     chk("unexpected_pkt_txid_seg", {txid, segment_num}, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("pkt_txid", txid, e / 65536);
                     chk("pkt_seg", segment_num, e % 65536);
                  end
                  if (in_round) begin
                     eg = (gap_override != 0) ? gap_override : GAP;
                     gap_override = 0;
                     chk("gap_len", gap_cnt, eg);
                  end
                  in_round = 1; pkt_len = 1; bad_seq = 0;
                  last_byte = int'(byte_data_counter);
               end else begin
                  if (int'(byte_data_counter) != last_byte + 1) bad_seq = 1;
                  last_byte = int'(byte_data_counter);
                  pkt_len++;
               end
               gap_cnt = 0;
            end else begin
               if (prev_tx) begin
                  chk("pkt_len", pkt_len, PB);
                  chk("pkt_byte_seq_ok", bad_seq, 0);
                  chk("gap_byte_zero", byte_data_counter, 0);
               end
               if (round_done) begin
                  chk("final_gap_len", gap_cnt, GAP);
                  chk("pkts_left_at_round_done", exp_q.size(), 0);
                  chk("round_done_expected", exp_rounds > 0, 1);
                  if (exp_rounds > 0) exp_rounds--;
                  in_round = 0; gap_cnt = 0; chk_idle = 1;
               end else if (in_round) begin
                  gap_cnt++;
               end
            end
            prev_tx = tx_active;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic start_round(input int red, input int seg, input int stop_pkts);
      @(negedge clk);
      redundancy      = 8'(red);
      segment_num_max = 16'(seg);
      model_round(red, seg, stop_pkts);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_round_done(input string name);
      int n = 0;
      while (round_done !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         checks++; errors++;
         $display("FAIL %s round_done timeout actual=%0d cycles required<20000", name, n);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_byte(input int t, input int s, input int b, input string name);
      int n = 0;
      while (!(tx_active === 1'b1 && int'(txid) == t && int'(segment_num) == s &&
               int'(byte_data_counter) == b) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         checks++; errors++;
         $display("FAIL %s byte wait timeout actual=%0d cycles required<20000", name, n);
      end
   endtask

   initial begin : driver
      bit seen;
      int r, s;
      rst_n = 1'b0; go = 1'b0; oneframe_done = 1'b0;
      redundancy = 8'd0; segment_num_max = 16'd0;
`ifdef TX_PAUSE_EN
      pause = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_tx_active", tx_active, 0);
      chk("rst_byte", byte_data_counter, 0);
      chk("rst_txid", txid, 1);
      chk("rst_seg", segment_num, 0);
      chk("rst_pkt_start", pkt_start, 0);
      chk("rst_round_done", round_done, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full round: 2 copies x 3 segments.
      start_round(2, 3, 0);
      wait_round_done("round_2x3");

      // Zero limits behave as one.
      start_round(0, 0, 0);
      wait_round_done("round_0x0");

      // Early stop during packet (1,1).
      start_round(2, 5, 2);
      wait_byte(1, 1, 700, "oneframe_wait");
      oneframe_done = 1'b1;
      @(negedge clk);
      oneframe_done = 1'b0;
      wait_round_done("round_oneframe");

      // Limit changes mid-round are ignored.
      start_round(1, 3, 0);
      segment_num_max = 16'd10;
      redundancy      = 8'd4;
      wait_round_done("round_midchange");

      // Reset at byte 300 of packet (1,1).
      start_round(2, 2, 0);
      wait_byte(1, 1, 300, "reset_wait");
      abort = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx_active", tx_active, 0);
      chk("mid_rst_byte", byte_data_counter, 0);
      chk("mid_rst_txid", txid, 1);
      chk("mid_rst_seg", segment_num, 0);
      chk("mid_rst_busy", busy, 0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (pkt_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      chk("no_start_without_go", seen, 0);
      abort = 1'b0;
      start_round(1, 1, 0);
      wait_round_done("round_after_reset");

`ifdef TX_PAUSE_EN
      // Pause across the last gap cycle: 10 normal gap cycles, 50 paused, 1 to leave.
      start_round(1, 2, 0);
      wait_byte(1, 0, PB - 1, "pause_wait");
      @(negedge clk);
      repeat (10) @(negedge clk);
      gap_override = 61;
      pause = 1'b1;
      repeat (50) @(negedge clk);
      pause = 1'b0;
      wait_round_done("round_pause");
`endif

      // Randomized small rounds.
      for (int i = 0; i < 3; i++) begin
         r = int'($urandom_range(0, 2));
         s = int'($urandom_range(0, 3));
         start_round(r, s, 0);
         wait_round_done("round_random");
      end

      chk("end_pkts_outstanding", exp_q.size(), 0);
      chk("end_rounds_outstanding", exp_rounds, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
